mdsa_out_serializer: RTL and testbench
======================================

// Module: mdsa_out_serializer
// PURPOSE
//  Downstream stage of the MDSA sorter top. Captures the sorted N*N-word matrix
//  (N*N*DW-bit bus) on the sorter's output_enable strobe. Emits it one DW-bit word
//  per handshake on a valid/ready stream.
//  Decouples the wide parallel sort result from a narrow consumer (FIFO/DMA/UART bridge).
// PARAMETERS
//  N      8   matrix dimension; frame = N*N words
//  DW     32  word width in bits
//  SNAKE  0   0: row-major order; 1: odd rows emitted right-to-left (snake order)
//  FCW    16  width of frame counter
// PORTS
//  clk         in   1         clock, rising edge
//  rst         in   1         synchronous reset, active-high
//  en          in   1         capture enable; gates acceptance of new frames only
//  out_en      in   1         sorter output_enable strobe; data_in valid this cycle
//  data_in     in   N*N*DW    sorted matrix; word k = data_in[k*DW +: DW], k=row*N+col
//  m_valid     out  1         stream word valid
//  m_ready     in   1         consumer ready
//  m_data      out  DW        stream word
//  m_last      out  1         high with final word (k = N*N-1 position) of frame
//  m_row       out  clog2(N)  row index of current m_data
//  m_col       out  clog2(N)  column index of current m_data
//  busy        out  1         frame held (capturing or draining)
//  overrun     out  1         sticky: a strobe was dropped while busy
//  frame_cnt   out  FCW       count of fully drained frames, wraps modulo 2^FCW
// BEHAVIOUR
//  - Reset values: m_valid=0, m_data=0, m_last=0, m_row=0, m_col=0, busy=0,
//    overrun=0, frame_cnt=0, FSM=IDLE.
//  - FSM states:
//    - IDLE: if out_en&&en at edge, latch data_in into frame buffer; go SEND.
//      Next cycle: m_valid=1, row=0, col=0.
//    - SEND: transfer on m_valid&&m_ready; then advance col, wrapping to next row.
//    - Latency: strobe edge -> first word valid = 1 cycle.
//  - Output ordering:
//    - SNAKE=0: word index = row*N+col.
//    - SNAKE=1, odd row: word index = row*N+(N-1-col). m_col reports logical col.
//  - Stream rules: once m_valid=1, m_data/m_last/m_row/m_col stay stable until handshake.
//    m_valid never drops mid-frame. m_ready may toggle freely; stalls are unbounded.
//  - m_last=1 exactly when row=N-1 and col=N-1.
//  - Last handshake: frame_cnt increments (wraps 2^FCW-1 -> 0). Then:
//    - out_en&&en same cycle: capture new frame, stay SEND, reset row/col=0,
//      m_valid stays 1 (zero-bubble back-to-back).
//    - else: go IDLE, m_valid=0 next cycle.
//  - out_en while SEND and not on last handshake: strobe ignored, buffer untouched,
//    overrun set (sticky until rst).
//  - en=0: new captures blocked, no overrun flagged; an in-flight frame still drains.
//  - out_en with en=0 in IDLE: ignored, no state change.
//  - busy = (FSM==SEND).
//  - rst mid-frame: frame discarded, all outputs to reset values next cycle;
//    frame_cnt not incremented.
//  - Buffer: single N*N*DW register, written only on capture. Output mux indexed by
//    {row,col}; m_data registered.
// STRUCTURE
//  - Shared package mdsa_pkg: N, DW, WORDS=N*N, IDXW=clog2(N), FW=WORDS*DW, state encoding
//    (IDLE, SEND). Same constants as sorter/FSM.
//  - One sub-module mdsa_rc_counter: row/col counter with advance, clear, last-flag outputs;
//    reusable by the upstream loader.
//  - Top holds FSM, frame buffer, snake index mapping, overrun/frame_cnt.
// TESTING
//  1. Reset: rst=1 2 cycles -> all outputs 0.
//     Strobe during rst -> ignored, m_valid stays 0.
//  2. Basic frame: word k=k+0x100, out_en 1 cycle, m_ready=1.
//     -> 64 consecutive words 0x100..0x13F, first 1 cycle after strobe.
//     -> m_last only on 0x13F; frame_cnt=1; busy low after.
//  3. Snake: SNAKE=1, same data.
//     -> row1 emits 0x10F..0x108.
//     -> row2 emits 0x110..0x117.
//     -> m_col tracks 0..7 on every row.
//  4. Backpressure: m_ready random ~50%.
//     -> data/last stable across every stall.
//     -> no word lost or duplicated (scoreboard 64 words).
//  5. Overrun/back-to-back:
//     - strobe at word 10 -> overrun=1, output sequence unchanged.
//     - strobe coincident with last handshake -> next frame word 0 on following cycle,
//       m_valid never low.
//  6. en gating and reset mid-frame:
//     - en=0 + strobe in IDLE -> no capture, overrun=0.
//     - rst at word 30 -> m_valid=0 next cycle, frame_cnt unchanged.

Source files
------------

// File: rtl/mdsa_pkg.sv
// Shared MDSA constants and FSM state encoding, common to the sorter, loader and serializer.
package mdsa_pkg;
    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int WORDS = N * N;
    localparam int IDXW  = $clog2(N);
    localparam int FW    = WORDS * DW;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;
endpackage

// File: rtl/mdsa_rc_counter.sv
// Row/column position counter over an N x N matrix.
// The next position is exported so a caller can prefetch the word it will point at.
import mdsa_pkg::*;

module mdsa_rc_counter #(
    parameter int N    = 8,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    output logic [IDXW-1:0] row,
    output logic [IDXW-1:0] col,
    output logic            last,
    output logic [IDXW-1:0] nrow,
    output logic [IDXW-1:0] ncol
);
    localparam logic [IDXW-1:0] LASTI = IDXW'(N - 1);

    assign last = (row == LASTI) && (col == LASTI);

    // Advancing from the final position wraps to (0,0).
    always_comb begin
        nrow = row;
        ncol = col + IDXW'(1);
        if (col == LASTI) begin
            ncol = '0;
            nrow = (row == LASTI) ? '0 : row + IDXW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            row <= nrow;
            col <= ncol;
        end
    end
endmodule

// File: rtl/mdsa_out_serializer.sv
// Captures a sorted N*N-word frame on the sorter strobe and streams it one word
// per valid/ready handshake, row-major or snake order.
import mdsa_pkg::*;

module mdsa_out_serializer #(
    parameter int N     = mdsa_pkg::N,
    parameter int DW    = mdsa_pkg::DW,
    parameter int SNAKE = 0,
    parameter int FCW   = 16,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              out_en,
    input  logic [N*N*DW-1:0] data_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic              m_last,
    output logic [IDXW-1:0]   m_row,
    output logic [IDXW-1:0]   m_col,
    output logic              busy,
    output logic              overrun,
    output logic [FCW-1:0]    frame_cnt
);
    localparam int WORDS = N * N;
    localparam int FW    = WORDS * DW;
    localparam int AW    = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [IDXW-1:0] LASTI = IDXW'(N - 1);

    state_e          state;
    logic [FW-1:0]   frame_q;
    logic [IDXW-1:0] nrow, ncol;
    logic            rc_last;
    logic            hs, take, fin, cap, adv;
    logic [AW-1:0]   rd_base;
    logic [DW-1:0]   nxt_word;

    // Odd rows are read mirrored in snake mode; m_col still reports the logical column.
    function automatic int widx(input logic [IDXW-1:0] r, input logic [IDXW-1:0] c);
        if (SNAKE != 0 && r[0])
            return int'(r) * N + (N - 1 - int'(c));
        return int'(r) * N + int'(c);
    endfunction

    assign hs   = m_valid && m_ready;
    assign take = out_en && en;
    assign fin  = (state == SEND) && hs && rc_last;
    assign cap  = take && ((state == IDLE) || fin);
    assign adv  = (state == SEND) && hs && !rc_last;
    assign busy = (state == SEND);

    assign rd_base  = AW'(widx(nrow, ncol) * DW);
    assign nxt_word = frame_q[rd_base +: DW];

    mdsa_rc_counter #(.N(N), .IDXW(IDXW)) u_rc (
        .clk  (clk),
        .rst  (rst),
        .clr  (cap || fin),
        .adv  (adv),
        .row  (m_row),
        .col  (m_col),
        .last (rc_last),
        .nrow (nrow),
        .ncol (ncol)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_last    <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        frame_q <= data_in;
                        m_data  <= data_in[DW-1:0];
                        m_valid <= 1'b1;
                        m_last  <= (WORDS == 1);
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (hs) begin
                        if (rc_last) begin
                            frame_cnt <= frame_cnt + FCW'(1);
                            if (take) begin
                                // Back-to-back frame: word 0 follows with no bubble.
                                frame_q <= data_in;
                                m_data  <= data_in[DW-1:0];
                                m_last  <= (WORDS == 1);
                            end else begin
                                m_valid <= 1'b0;
                                m_last  <= 1'b0;
                                state   <= IDLE;
                            end
                        end else begin
                            m_data <= nxt_word;
                            m_last <= (nrow == LASTI) && (ncol == LASTI);
                        end
                    end
                    if (take && !fin)
                        overrun <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdsa_out_serializer.sv
// Directed bench for mdsa_out_serializer: row-major and snake instances share stimulus.
module tb_mdsa_out_serializer;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int FCW = 16;

    logic              clk = 1'b0;
    logic              rst, en, out_en, m_ready;
    logic [N*N*DW-1:0] data_in;

    logic            v0, l0, b0, o0, v1, l1, b1, o1;
    logic [DW-1:0]   d0, d1;
    logic [2:0]      r0, c0, r1, c1;
    logic [FCW-1:0]  f0, f1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdsa_out_serializer #(.N(N), .DW(DW), .SNAKE(0), .FCW(FCW)) dut0 (
        .clk(clk), .rst(rst), .en(en), .out_en(out_en), .data_in(data_in),
        .m_valid(v0), .m_ready(m_ready), .m_data(d0), .m_last(l0),
        .m_row(r0), .m_col(c0), .busy(b0), .overrun(o0), .frame_cnt(f0));

    mdsa_out_serializer #(.N(N), .DW(DW), .SNAKE(1), .FCW(FCW)) dut1 (
        .clk(clk), .rst(rst), .en(en), .out_en(out_en), .data_in(data_in),
        .m_valid(v1), .m_ready(m_ready), .m_data(d1), .m_last(l1),
        .m_row(r1), .m_col(c1), .busy(b1), .overrun(o1), .frame_cnt(f1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] base);
        for (int k = 0; k < N*N; k++)
            data_in[k*DW +: DW] = base + 32'(k);
    endtask

    initial begin
        logic [DW-1:0] held_d;
        logic          held_l;
        logic          stalled;
        int            idx;
        int            cyc;

        rst = 1'b1; en = 1'b1; out_en = 1'b1; m_ready = 1'b1;
        load(32'h0);
        // Reset, with a strobe asserted throughout
        step(); step();
        chk("rst_valid", 64'(v0), 64'd0);
        chk("rst_data",  64'(d0), 64'd0);
        chk("rst_last",  64'(l0), 64'd0);
        chk("rst_row",   64'(r0), 64'd0);
        chk("rst_col",   64'(c0), 64'd0);
        chk("rst_busy",  64'(b0), 64'd0);
        chk("rst_ovr",   64'(o0), 64'd0);
        chk("rst_fcnt",  64'(f0), 64'd0);
        chk("rst_valid1", 64'(v1), 64'd0);
        rst = 1'b0; out_en = 1'b0;
        step();
        chk("rst_strobe_ignored", 64'(v0), 64'd0);

        // Basic frame, plus snake ordering on dut1
        load(32'h100); out_en = 1'b1;
        step();
        out_en = 1'b0;
        for (int k = 0; k < N*N; k++) begin
            int row, col, sk;
            row = k / N; col = k % N;
            sk  = (row % 2 == 1) ? row*N + (N-1-col) : k;
            chk("b_valid", 64'(v0), 64'd1);
            chk("b_data",  64'(d0), 64'(32'h100 + k));
            chk("b_last",  64'(l0), 64'(k == N*N-1));
            chk("b_row",   64'(r0), 64'(row));
            chk("b_col",   64'(c0), 64'(col));
            chk("b_busy",  64'(b0), 64'd1);
            chk("s_data",  64'(d1), 64'(32'h100 + sk));
            chk("s_col",   64'(c1), 64'(col));
            chk("s_last",  64'(l1), 64'(k == N*N-1));
            step();
        end
        chk("b_done_valid", 64'(v0), 64'd0);
        chk("b_done_busy",  64'(b0), 64'd0);
        chk("b_fcnt",       64'(f0), 64'd1);
        chk("s_fcnt",       64'(f1), 64'd1);

        // Random backpressure with in-order scoreboard
        load(32'h200); out_en = 1'b1;
        step();
        out_en = 1'b0;
        idx = 0; stalled = 1'b0; cyc = 0;
        while (idx < N*N && cyc < 1000) begin
            chk("bp_valid", 64'(v0), 64'd1);
            if (stalled) begin
                chk("bp_hold_data", 64'(d0), 64'(held_d));
                chk("bp_hold_last", 64'(l0), 64'(held_l));
            end
            m_ready = 1'($urandom_range(0, 1));
            if (m_ready) begin
                chk("bp_word", 64'(d0), 64'(32'h200 + idx));
                chk("bp_last", 64'(l0), 64'(idx == N*N-1));
                idx++;
                stalled = 1'b0;
            end else begin
                held_d = d0; held_l = l0; stalled = 1'b1;
            end
            step();
            cyc++;
        end
        if (idx < N*N) chk("bp_timeout", 64'(idx), 64'(N*N));
        m_ready = 1'b1;
        chk("bp_done_valid", 64'(v0), 64'd0);
        chk("bp_fcnt",       64'(f0), 64'd2);

        // Overrun mid-frame, then back-to-back on the last handshake
        load(32'h300); out_en = 1'b1;
        step();
        out_en = 1'b0;
        for (int k = 0; k < N*N; k++) begin
            chk("ov_valid", 64'(v0), 64'd1);
            chk("ov_data",  64'(d0), 64'(32'h300 + k));
            if (k == 10) chk("ov_before", 64'(o0), 64'd0);
            if (k == 11) chk("ov_set",    64'(o0), 64'd1);
            out_en = 1'b0;
            if (k == 10) begin load(32'h900); out_en = 1'b1; end
            if (k == N*N-1) begin load(32'h400); out_en = 1'b1; end
            step();
        end
        out_en = 1'b0;
        chk("b2b_valid", 64'(v0), 64'd1);
        chk("b2b_data",  64'(d0), 64'h400);
        chk("b2b_row",   64'(r0), 64'd0);
        chk("b2b_col",   64'(c0), 64'd0);
        chk("b2b_fcnt",  64'(f0), 64'd3);
        chk("b2b_ovr",   64'(o0), 64'd1);
        for (int k = 0; k < N*N; k++) begin
            chk("b2b_vk", 64'(v0), 64'd1);
            chk("b2b_dk", 64'(d0), 64'(32'h400 + k));
            step();
        end
        chk("b2b_end_valid", 64'(v0), 64'd0);
        chk("b2b_end_fcnt",  64'(f0), 64'd4);

        // en gating and reset mid-frame
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("r2_ovr",  64'(o0), 64'd0);
        chk("r2_fcnt", 64'(f0), 64'd0);
        en = 1'b0; out_en = 1'b1; load(32'h600);
        step();
        out_en = 1'b0;
        chk("en0_valid", 64'(v0), 64'd0);
        chk("en0_busy",  64'(b0), 64'd0);
        chk("en0_ovr",   64'(o0), 64'd0);
        en = 1'b1; load(32'h500); out_en = 1'b1;
        step();
        out_en = 1'b0;
        for (int k = 0; k <= 30; k++) begin
            chk("mr_valid", 64'(v0), 64'd1);
            chk("mr_data",  64'(d0), 64'(32'h500 + k));
            en = (k != 5); out_en = (k == 5);
            if (k == 30) begin en = 1'b1; out_en = 1'b0; rst = 1'b1; end
            step();
        end
        rst = 1'b0;
        chk("mr_en0_ovr", 64'(o0), 64'd0);
        chk("mr_valid0",  64'(v0), 64'd0);
        chk("mr_fcnt",    64'(f0), 64'd0);
        chk("mr_busy",    64'(b0), 64'd0);
        chk("mr_data0",   64'(d0), 64'd0);
        chk("mr_row0",    64'(r0), 64'd0);
        chk("mr_col0",    64'(c0), 64'd0);
        step();
        chk("mr_stay_idle", 64'(v0), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
